// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage <-> HiLo sequencer bundle: op request, HiLo read request, and the single-cycle HiLo commit port.
// master = execute stage / HiLo register side, slave = the sequencer.
interface hilo_muldiv_ctrl_if;
  logic        Start;
  logic [2:0]  Func;
  logic [31:0] A;
  logic [31:0] B;
  logic        ReadReq;
  logic        Busy;
  logic        Stall;
  logic        Done;
  logic        DivByZero;
  logic [63:0] WriteData;
  logic [1:0]  Op;
  logic        RegWriteH;
  logic        RegWriteL;

  modport master (
    output Start, Func, A, B, ReadReq,
    input  Busy, Stall, Done, DivByZero, WriteData, Op, RegWriteH, RegWriteL
  );

  modport slave (
    input  Start, Func, A, B, ReadReq,
    output Busy, Stall, Done, DivByZero, WriteData, Op, RegWriteH, RegWriteL
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle mul/div sequencer and sole writer of HiLo; commit lands MUL_LAT cycles (mul), 34 (div) or 1 (MTHI/MTLO) after Start.
// No queueing: Start/ReadReq while busy raise Stall and the op must be re-presented.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 4
) (
  input logic              Clk,
  input logic              Rst,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] F_MULT  = 3'd0;
  localparam logic [2:0] F_MULTU = 3'd1;
  localparam logic [2:0] F_MADD  = 3'd2;
  localparam logic [2:0] F_MSUB  = 3'd3;
  localparam logic [2:0] F_DIV   = 3'd4;
  localparam logic [2:0] F_DIVU  = 3'd5;
  localparam logic [2:0] F_MTHI  = 3'd6;
  localparam logic [2:0] F_MTLO  = 3'd7;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, COMMIT} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  funcQ;
  logic [63:0] acc;        // product for mul ops, {remainder, quotient} while dividing
  logic [31:0] divisor;
  logic        negQ;
  logic        negR;

  logic        done;
  logic        divByZero;
  logic [63:0] writeData;
  logic [1:0]  op;
  logic        regWriteH;
  logic        regWriteL;
  logic        busy;

  logic [63:0] sProd;
  logic [63:0] uProd;
  logic [63:0] prodNext;
  logic        isSignedDiv;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [32:0] shRem;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] remNext;
  logic [31:0] quoNext;
  logic [31:0] quoFix;
  logic [31:0] remFix;

  function automatic logic [1:0] mulOp(input logic [2:0] f);
    case (f)
      F_MADD:  return 2'd1;
      F_MSUB:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Accumulate ops ride on Op alone; HiLo ignores the write enables for them.
  function automatic logic mulWr(input logic [2:0] f);
    return (f == F_MULT) || (f == F_MULTU);
  endfunction

  assign sProd    = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign uProd    = {32'd0, bus.A} * {32'd0, bus.B};
  assign prodNext = (bus.Func == F_MULTU) ? uProd : sProd;

  assign isSignedDiv = (bus.Func == F_DIV);
  assign aMag = (isSignedDiv && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
  assign bMag = (isSignedDiv && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

  // Restoring step: shift next dividend bit into the partial remainder and try the subtract.
  assign shRem   = {acc[63:32], acc[31]};
  assign trial   = shRem - {1'b0, divisor};
  assign fits    = ~trial[32];
  assign remNext = fits ? trial[31:0] : shRem[31:0];
  assign quoNext = {acc[30:0], fits};

  assign quoFix = negQ ? (32'd0 - acc[31:0])  : acc[31:0];
  assign remFix = negR ? (32'd0 - acc[63:32]) : acc[63:32];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      funcQ     <= '0;
      acc       <= '0;
      divisor   <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      writeData <= '0;
      op        <= 2'd0;
      regWriteH <= 1'b0;
      regWriteL <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      writeData <= '0;
      op        <= 2'd0;
      regWriteH <= 1'b0;
      regWriteL <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Start) begin
            funcQ <= bus.Func;
            case (bus.Func)
              F_MULT, F_MULTU, F_MADD, F_MSUB: begin
                acc <= prodNext;
                if (MUL_LAT <= 1) begin
                  state     <= COMMIT;
                  done      <= 1'b1;
                  writeData <= prodNext;
                  op        <= mulOp(bus.Func);
                  regWriteH <= mulWr(bus.Func);
                  regWriteL <= mulWr(bus.Func);
                end else begin
                  cnt   <= 5'(MUL_LAT - 1);
                  state <= MUL;
                end
              end
              F_DIV, F_DIVU: begin
                if (bus.B == 32'd0) begin
                  divByZero <= 1'b1;
                end else begin
                  state   <= DIV;
                  cnt     <= 5'd31;
                  acc     <= {32'd0, aMag};
                  divisor <= bMag;
                  negQ    <= isSignedDiv && (bus.A[31] ^ bus.B[31]);
                  negR    <= isSignedDiv && bus.A[31];
                end
              end
              F_MTHI: begin
                state     <= COMMIT;
                done      <= 1'b1;
                writeData <= {bus.A, 32'd0};
                regWriteH <= 1'b1;
              end
              default: begin
                state     <= COMMIT;
                done      <= 1'b1;
                writeData <= {32'd0, bus.A};
                regWriteL <= 1'b1;
              end
            endcase
          end
        end

        MUL: begin
          if (cnt <= 5'd1) begin
            cnt       <= '0;
            state     <= COMMIT;
            done      <= 1'b1;
            writeData <= acc;
            op        <= mulOp(funcQ);
            regWriteH <= mulWr(funcQ);
            regWriteL <= mulWr(funcQ);
          end else begin
            cnt <= cnt - 5'd1;
          end
        end

        DIV: begin
          acc <= {remNext, quoNext};
          if (cnt == 5'd0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end

        FIX: begin
          state     <= COMMIT;
          done      <= 1'b1;
          writeData <= {remFix, quoFix};
          regWriteH <= 1'b1;
          regWriteL <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign bus.Busy      = busy;
  assign bus.Stall     = busy & (bus.Start | bus.ReadReq);
  assign bus.Done      = done;
  assign bus.DivByZero = divByZero;
  assign bus.WriteData = writeData;
  assign bus.Op        = op;
  assign bus.RegWriteH = regWriteH;
  assign bus.RegWriteL = regWriteL;

endmodule
